// File: rtl/program_loader_if.sv
// Bundles the loader's byte-stream handshake, instruction-memory write bus and
// CPU/status controls. The master side is the loader; the slave side is the
// byte source / memory / CPU environment around it.
interface program_loader_if #(
  parameter int WORD_CNT_W = 8
);
  logic                  start;
  logic [WORD_CNT_W-1:0] prog_len;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  LoadInstructions;
  logic [31:0]           Instruction;
  logic [31:0]           load_addr;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, prog_len, byte_in, byte_valid,
    output byte_ready, LoadInstructions, Instruction, load_addr,
           cpu_reset, busy, done
  );

  modport slave (
    output start, prog_len, byte_in, byte_valid,
    input  byte_ready, LoadInstructions, Instruction, load_addr,
           cpu_reset, busy, done
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: collects a byte stream, packs every 4 bytes big-endian into a
// 32-bit instruction and writes it to instruction memory with a one-cycle
// strobe and explicit address. Keeps the CPU in reset from Reset until the last
// word is written plus HOLD_CYC settle cycles.
module program_loader #(
  parameter int WORD_CNT_W = 8,
  parameter int ADDR_STEP  = 1,
  parameter int HOLD_CYC   = 4
) (
  input  logic clk,
  input  logic Reset,
  program_loader_if.master bus
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    HOLD,
    DONE
  } stateT;

  stateT stateReg;
  stateT stateNext;

  logic [WORD_CNT_W-1:0] progLenReg;
  logic [WORD_CNT_W-1:0] wordIdxReg;
  logic [WORD_CNT_W-1:0] wordIdxInc;
  logic [1:0]            byteIdxReg;
  // Only the three most recent bytes need to be kept; the fourth arrives live.
  logic [23:0]           asmReg;
  logic [31:0]           asmShifted;
  logic [31:0]           instrReg;
  logic [31:0]           addrReg;
  logic [HOLD_W-1:0]     holdCntReg;
  logic                  holdLast;
  logic                  startFire;
  logic                  byteFire;

  // byte_ready is exactly "in COLLECT", so a transfer is valid-in-COLLECT.
  assign startFire  = bus.start && ((stateReg == IDLE) || (stateReg == DONE));
  assign byteFire   = bus.byte_valid && (stateReg == COLLECT);
  assign wordIdxInc = wordIdxReg + 1'b1;
  assign holdLast   = (holdCntReg == HOLD_W'(HOLD_CYC - 1));

  // Byte lanes of the word being assembled: newest byte lands in the LSB lane,
  // older bytes move one lane up, so the first byte ends up most significant.
  assign asmShifted[7:0] = bus.byte_in;
  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : gLane
      assign asmShifted[8*gi +: 8] = asmReg[8*(gi-1) +: 8];
    end
  endgenerate

  assign bus.Instruction = instrReg;
  assign bus.load_addr   = addrReg;

  // State register; Reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (Reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    stateNext            = stateReg;
    bus.byte_ready       = 1'b0;
    bus.LoadInstructions = 1'b0;
    bus.cpu_reset        = 1'b1;
    bus.busy             = 1'b0;
    bus.done             = 1'b0;
    case (stateReg)
      IDLE: begin
        if (bus.start) begin
          stateNext = (bus.prog_len == '0) ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        bus.byte_ready = 1'b1;
        bus.busy       = 1'b1;
        if (bus.byte_valid && (byteIdxReg == 2'd3)) begin
          stateNext = WRITE;
        end
      end
      WRITE: begin
        bus.LoadInstructions = 1'b1;
        bus.busy             = 1'b1;
        stateNext            = (wordIdxInc == progLenReg) ? HOLD : COLLECT;
      end
      HOLD: begin
        bus.busy = 1'b1;
        if (holdLast) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        bus.cpu_reset = 1'b0;
        bus.done      = 1'b1;
        if (bus.start) begin
          stateNext = (bus.prog_len == '0) ? HOLD : COLLECT;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath: length latch, byte/word counters, word assembly, output word and
  // address registers (loaded on the 4th byte so they are valid during WRITE and
  // hold afterwards), and the settle-delay counter.
  always_ff @(posedge clk) begin
    if (Reset) begin
      progLenReg <= '0;
      wordIdxReg <= '0;
      byteIdxReg <= '0;
      asmReg     <= '0;
      instrReg   <= '0;
      addrReg    <= '0;
      holdCntReg <= '0;
    end else begin
      if (startFire) begin
        progLenReg <= bus.prog_len;
        wordIdxReg <= '0;
        byteIdxReg <= '0;
        asmReg     <= '0;
      end
      if (byteFire) begin
        asmReg     <= asmShifted[23:0];
        byteIdxReg <= byteIdxReg + 2'd1;
        if (byteIdxReg == 2'd3) begin
          instrReg <= asmShifted;
          addrReg  <= 32'(wordIdxReg) * 32'(ADDR_STEP);
        end
      end
      if (stateReg == WRITE) begin
        wordIdxReg <= wordIdxInc;
      end
      if (stateReg == HOLD) begin
        holdCntReg <= holdLast ? '0 : holdCntReg + 1'b1;
      end else begin
        holdCntReg <= '0;
      end
    end
  end

endmodule
